// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_arbiter SRAM access controller.
package mem_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE   = 2'd0,
    STATE_ACCESS = 2'd1,
    STATE_WAIT   = 2'd2
  } state_t;

  localparam int MAX_RD_LATENCY = 4;
  localparam int CNT_W          = $clog2(MAX_RD_LATENCY + 1);

endpackage

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter: one-hot grant searched from pointer+1, pointer moves to the winner on update.
module rr_arbiter
  import mem_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N-1:0]         req_i,
  input  logic                 update_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] cand_s;
  logic             hit_s;
  logic             found_s;

  // First requester after the pointer wins; later candidates are masked by found_s.
  always_comb begin
    gnt_o   = '0;
    idx_o   = ptr_q;
    cand_s  = '0;
    hit_s   = 1'b0;
    found_s = 1'b0;
    for (int i = 1; i <= N; i++) begin
      cand_s        = IDX_W'((int'(ptr_q) + i) % N);
      hit_s         = req_i[cand_s] & ~found_s;
      gnt_o[cand_s] = hit_s;
      idx_o         = hit_s ? cand_s : idx_o;
      found_s       = found_s | hit_s;
    end
  end

  always_comb begin
    ptr_d = update_i ? idx_o : ptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= IDX_W'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-client single-port SRAM access controller: round-robin grant, one-cycle SRAM access,
// read data returned to the owner after RD_LATENCY cycles. Accesses never overlap.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int N_CLIENTS  = 4,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [N_CLIENTS-1:0]              req_i,
  input  logic [N_CLIENTS-1:0]              we_i,
  input  logic [N_CLIENTS-1:0][ADDR_W-1:0]  addr_i,
  input  logic [N_CLIENTS-1:0][DATA_W-1:0]  wdata_i,
  output logic [N_CLIENTS-1:0]              gnt_o,
  output logic [N_CLIENTS-1:0]              rvalid_o,
  output logic [DATA_W-1:0]                 rdata_o,
  output logic                              busy_o,
  output logic                              mem_en_o,
  output logic                              mem_we_o,
  output logic [ADDR_W-1:0]                 mem_addr_o,
  output logic [DATA_W-1:0]                 mem_wdata_o,
  input  logic [DATA_W-1:0]                 mem_rdata_i
);

  localparam int IDX_W = $clog2(N_CLIENTS);

  if (N_CLIENTS < 2 || N_CLIENTS > 8) begin : g_bad_n_clients
    $error("mem_arbiter: N_CLIENTS must lie in 2..8");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_rd_latency
    $error("mem_arbiter: RD_LATENCY must lie in 1..MAX_RD_LATENCY");
  end

  state_t                state_q;
  state_t                state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic                  we_q;
  logic                  we_d;
  logic [ADDR_W-1:0]     addr_q;
  logic [ADDR_W-1:0]     addr_d;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     wdata_d;
  logic [IDX_W-1:0]      owner_q;
  logic [IDX_W-1:0]      owner_d;

  logic [N_CLIENTS-1:0]  arb_req_s;
  logic [N_CLIENTS-1:0]  arb_gnt_s;
  logic [IDX_W-1:0]      arb_idx_s;
  logic                  grant_s;
  logic                  mem_en_s;
  logic                  rd_done_s;

  // Requests are only visible to the arbiter in IDLE, so no grant can leak out mid-access.
  assign arb_req_s = (state_q == STATE_IDLE) ? req_i : '0;
  assign grant_s   = |arb_gnt_s;

  rr_arbiter #(
    .N (N_CLIENTS)
  ) u_rr_arbiter (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (arb_req_s),
    .update_i (grant_s),
    .gnt_o    (arb_gnt_s),
    .idx_o    (arb_idx_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    owner_d = owner_q;
    case (state_q)
      STATE_IDLE: begin
        if (grant_s) begin
          state_d = STATE_ACCESS;
          we_d    = we_i[arb_idx_s];
          addr_d  = addr_i[arb_idx_s];
          wdata_d = wdata_i[arb_idx_s];
          owner_d = arb_idx_s;
        end else begin
          state_d = STATE_IDLE;
        end
      end
      STATE_ACCESS: begin
        if (we_q) begin
          state_d = STATE_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = STATE_WAIT;
          cnt_d   = CNT_W'(RD_LATENCY);
        end
      end
      STATE_WAIT: begin
        // A zero count can only come from corruption; leave WAIT rather than underflow.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = STATE_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = STATE_WAIT;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = STATE_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= STATE_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      owner_q <= owner_d;
    end
  end

  // SRAM pins are decoded from the state register so reset clears them asynchronously.
  assign mem_en_s    = (state_q == STATE_ACCESS);
  assign rd_done_s   = (state_q == STATE_WAIT) && (cnt_q == CNT_W'(1));

  assign gnt_o       = arb_gnt_s;
  assign busy_o      = (state_q != STATE_IDLE);
  assign mem_en_o    = mem_en_s;
  assign mem_we_o    = mem_en_s & we_q;
  assign mem_addr_o  = mem_en_s ? addr_q : '0;
  assign mem_wdata_o = mem_en_s ? wdata_q : '0;
  assign rvalid_o    = rd_done_s ? (N_CLIENTS'(1) << owner_q) : '0;
  assign rdata_o     = rd_done_s ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run against a
// schedule-based reference model (grant cycle -> access cycle -> data-return cycle).
module tb_mem_arbiter;

  localparam int NC  = 4;
  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int LAT = 3;

  logic clk    = 1'b0;
  logic rst_ni = 1'b0;

  logic [NC-1:0]         req, we, gnt, rvalid;
  logic [NC-1:0][AW-1:0] addr;
  logic [NC-1:0][DW-1:0] wdata;
  logic [DW-1:0]         rdata, mem_wdata, mem_rdata;
  logic                  busy, mem_en, mem_we;
  logic [AW-1:0]         mem_addr;

  logic [NC-1:0]         req_b, we_b, gnt_b, rvalid_b;
  logic [NC-1:0][AW-1:0] addr_b;
  logic [NC-1:0][DW-1:0] wdata_b;
  logic [DW-1:0]         rdata_b, wdata_o_b, rdata_in_b;
  logic                  busy_b, en_b, we_o_b;
  logic [AW-1:0]         addr_o_b;

  int cmp_n = 0;
  int err_n = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.N_CLIENTS(NC), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .busy_o(busy), .mem_en_o(mem_en),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  mem_arbiter #(.N_CLIENTS(NC), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)) dut_l1 (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_b), .we_i(we_b), .addr_i(addr_b), .wdata_i(wdata_b),
    .gnt_o(gnt_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b), .busy_o(busy_b), .mem_en_o(en_b),
    .mem_we_o(we_o_b), .mem_addr_o(addr_o_b), .mem_wdata_o(wdata_o_b), .mem_rdata_i(rdata_in_b)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {22'h0, a} * 32'h9E37_79B1;
  endfunction

  // Behavioural SRAM for the main DUT: LAT-deep read pipeline, noise when not reading.
  logic [DW-1:0] sram_a [1024];
  bit            wr_a   [1024];
  logic [DW-1:0] pipe_a [LAT];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      sram_a[mem_addr] <= mem_wdata;
      wr_a[mem_addr]   <= 1'b1;
    end
    if (mem_en && !mem_we) pipe_a[0] <= wr_a[mem_addr] ? sram_a[mem_addr] : init_val(mem_addr);
    else pipe_a[0] <= $urandom;
    for (int i = 1; i < LAT; i++) pipe_a[i] <= pipe_a[i-1];
  end
  assign mem_rdata = pipe_a[LAT-1];

  // Single-cycle read-only SRAM for the latency-1 DUT, address 5 holds 0xDEADBEEF.
  always @(posedge clk) begin
    if (en_b && !we_o_b) rdata_in_b <= (addr_o_b == 10'd5) ? 32'hDEAD_BEEF : init_val(addr_o_b);
    else rdata_in_b <= $urandom;
  end

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req = '0; we = '0; addr = '0; wdata = '0;
    req_b = '0; we_b = '0; addr_b = '0; wdata_b = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    to_drive();
    to_drive();
    rst_ni = 1'b1;
  endtask

  // ---------------- reference model ----------------
  logic [1:0]    m_ptr;
  int            m_free, m_acc, m_rv;
  logic [1:0]    m_rvc;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rvd;
  logic [DW-1:0] ref_mem [1024];
  logic [NC-1:0] exp_gnt, exp_rv;
  logic          exp_busy, exp_en, exp_mwe;
  logic [AW-1:0] exp_maddr;
  logic [DW-1:0] exp_mwd, exp_rd;

  task automatic model_eval(input int cyc);
    logic [1:0] c;
    logic [1:0] w;
    bit         found;
    exp_busy  = (cyc < m_free);
    exp_en    = (cyc == m_acc);
    exp_mwe   = exp_en & m_we;
    exp_maddr = exp_en ? m_addr : '0;
    exp_mwd   = exp_en ? m_wdata : '0;
    exp_rv    = (cyc == m_rv) ? (4'b0001 << m_rvc) : 4'b0000;
    exp_rd    = (cyc == m_rv) ? m_rvd : '0;
    exp_gnt   = '0;
    found     = 1'b0;
    w         = 2'd0;
    if (!exp_busy) begin
      for (int k = 1; k <= NC; k++) begin
        c = 2'((int'(m_ptr) + k) % NC);
        if (!found && req[c]) begin
          found = 1'b1;
          w     = c;
        end
      end
    end
    if (found) begin
      exp_gnt = 4'b0001 << w;
      m_ptr   = w;
      m_acc   = cyc + 1;
      m_we    = we[w];
      m_addr  = addr[w];
      m_wdata = wdata[w];
      if (we[w]) begin
        ref_mem[addr[w]] = wdata[w];
        m_free = cyc + 2;
      end else begin
        m_rv   = cyc + 1 + LAT;
        m_rvc  = w;
        m_rvd  = ref_mem[addr[w]];
        m_free = cyc + 2 + LAT;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    to_drive();
    to_drive();
    cmp_n++; if (gnt !== 4'b0000) begin err_n++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    cmp_n++; if (busy !== 1'b0) begin err_n++; $display("FAIL reset_busy: got %b want 0", busy); end
    cmp_n++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      err_n++; $display("FAIL reset_mem_bus: en=%b we=%b addr=%h wdata=%h want all 0", mem_en, mem_we, mem_addr, mem_wdata); end
    cmp_n++; if ({rvalid, rdata} !== '0) begin
      err_n++; $display("FAIL reset_rvalid_rdata: rvalid=%b rdata=%h want 0", rvalid, rdata); end
    cmp_n++; if ({busy_b, en_b, we_o_b, addr_o_b, wdata_o_b, rvalid_b, rdata_b} !== '0) begin
      err_n++; $display("FAIL reset_l1_outputs: busy=%b en=%b not all 0", busy_b, en_b); end
    req = 4'b0110;
    #2;
    cmp_n++; if (gnt !== 4'b0010) begin err_n++; $display("FAIL reset_gnt_follows_req: got %b want 0010", gnt); end
    idle_inputs();
    to_drive();
    rst_ni = 1'b1;
  endtask

  task automatic test_single_write();
    req = 4'b0100; we = 4'b0100; addr[2] = 10'h005; wdata[2] = 32'hDEAD_BEEF;
    to_sample();
    cmp_n++; if (gnt !== 4'b0100) begin err_n++; $display("FAIL write_gnt: got %b want 0100", gnt); end
    to_drive();
    idle_inputs();
    to_sample();
    cmp_n++; if ({mem_en, mem_we} !== 2'b11) begin err_n++; $display("FAIL write_en_we: got %b want 11", {mem_en, mem_we}); end
    cmp_n++; if (mem_addr !== 10'h005) begin err_n++; $display("FAIL write_addr: got %h want 005", mem_addr); end
    cmp_n++; if (mem_wdata !== 32'hDEAD_BEEF) begin err_n++; $display("FAIL write_wdata: got %h want deadbeef", mem_wdata); end
    cmp_n++; if (busy !== 1'b1) begin err_n++; $display("FAIL write_busy_access: got %b want 1", busy); end
    to_drive();
    to_sample();
    cmp_n++; if ({busy, mem_en, mem_addr} !== '0) begin
      err_n++; $display("FAIL write_done_idle: busy=%b en=%b addr=%h want 0", busy, mem_en, mem_addr); end
    to_drive();
  endtask

  task automatic test_read_latency();
    logic [NC-1:0] want_a, want_b;
    req = 4'b0001; addr[0] = 10'h005;
    req_b = 4'b0001; addr_b[0] = 10'h005;
    to_sample();
    cmp_n++; if ({gnt, gnt_b} !== 8'b0001_0001) begin
      err_n++; $display("FAIL read_gnt: got %b/%b want 0001/0001", gnt, gnt_b); end
    for (int k = 1; k <= 6; k++) begin
      to_drive();
      idle_inputs();
      to_sample();
      want_a = (k == 1 + LAT) ? 4'b0001 : 4'b0000;
      want_b = (k == 2) ? 4'b0001 : 4'b0000;
      cmp_n++; if (rvalid !== want_a) begin err_n++; $display("FAIL read_l3_rvalid t+%0d: got %b want %b", k, rvalid, want_a); end
      cmp_n++; if (rdata !== ((k == 1 + LAT) ? 32'hDEAD_BEEF : 32'h0)) begin
        err_n++; $display("FAIL read_l3_rdata t+%0d: got %h", k, rdata); end
      cmp_n++; if (rvalid_b !== want_b) begin err_n++; $display("FAIL read_l1_rvalid t+%0d: got %b want %b", k, rvalid_b, want_b); end
      cmp_n++; if (rdata_b !== ((k == 2) ? 32'hDEAD_BEEF : 32'h0)) begin
        err_n++; $display("FAIL read_l1_rdata t+%0d: got %h", k, rdata_b); end
    end
    to_drive();
  endtask

  logic [DW-1:0] fw [NC];

  task automatic test_fairness();
    logic [NC-1:0] want;
    do_reset();
    for (int i = 0; i < NC; i++) begin
      fw[i] = $urandom;
      addr[i] = 10'h010 + 10'(i);
      wdata[i] = fw[i];
    end
    req = 4'b1111; we = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      to_sample();
      want = ((k % 2) == 0) ? (4'b0001 << ((k / 2) % NC)) : 4'b0000;
      cmp_n++; if (gnt !== want) begin err_n++; $display("FAIL fair_gnt k=%0d: got %b want %b", k, gnt, want); end
      if ((k % 2) == 1) begin
        cmp_n++; if (mem_addr !== 10'h010 + 10'((k / 2) % NC)) begin
          err_n++; $display("FAIL fair_mem_addr k=%0d: got %h", k, mem_addr); end
      end
      to_drive();
      if (k == 14) idle_inputs();
    end
  endtask

  task automatic test_withdraw_contention();
    req = 4'b1000; addr[3] = 10'h011;
    to_sample();
    cmp_n++; if (gnt !== 4'b1000) begin err_n++; $display("FAIL wd_gnt3: got %b want 1000", gnt); end
    for (int k = 1; k <= 4; k++) begin
      to_drive();
      if (k == 1) req = 4'b0000;
      if (k == 2) begin req = 4'b0011; addr[0] = 10'h012; addr[1] = 10'h013; end
      if (k == 4) req = 4'b0001;
      to_sample();
      cmp_n++; if (gnt !== 4'b0000) begin err_n++; $display("FAIL wd_no_gnt_busy t+%0d: got %b want 0000", k, gnt); end
    end
    cmp_n++; if (rvalid !== 4'b1000) begin err_n++; $display("FAIL wd_rvalid: got %b want 1000", rvalid); end
    cmp_n++; if (rdata !== fw[1]) begin err_n++; $display("FAIL wd_rdata: got %h want %h", rdata, fw[1]); end
    to_drive();
    to_sample();
    cmp_n++; if (gnt !== 4'b0001) begin err_n++; $display("FAIL wd_next_gnt: got %b want 0001", gnt); end
    to_drive();
    idle_inputs();
    for (int k = 0; k < 6; k++) to_drive();
  endtask

  task automatic test_reset_mid_read();
    req = 4'b0001; addr[0] = 10'h005;
    to_sample();
    cmp_n++; if (gnt !== 4'b0001) begin err_n++; $display("FAIL rmr_gnt: got %b want 0001", gnt); end
    to_drive();
    idle_inputs();
    to_sample();
    cmp_n++; if (mem_en !== 1'b1) begin err_n++; $display("FAIL rmr_access_en: got %b want 1", mem_en); end
    to_drive();
    to_sample();
    cmp_n++; if (busy !== 1'b1) begin err_n++; $display("FAIL rmr_wait_busy: got %b want 1", busy); end
    rst_ni = 1'b0;
    #1;
    cmp_n++; if ({gnt, rvalid, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      err_n++; $display("FAIL rmr_outputs_zero: busy=%b en=%b rvalid=%b rdata=%h want 0", busy, mem_en, rvalid, rdata); end
    to_drive();
    rst_ni = 1'b1;
    for (int k = 0; k < 6; k++) begin
      to_sample();
      cmp_n++; if ({rvalid, rdata, busy} !== '0) begin
        err_n++; $display("FAIL rmr_no_rvalid k=%0d: rvalid=%b rdata=%h busy=%b", k, rvalid, rdata, busy); end
      to_drive();
    end
    req = 4'b0001; addr[0] = 10'h005;
    to_sample();
    cmp_n++; if (gnt !== 4'b0001) begin err_n++; $display("FAIL rmr_first_gnt: got %b want 0001", gnt); end
    to_drive();
    idle_inputs();
    for (int k = 0; k < 6; k++) to_drive();
  endtask

  task automatic test_random();
    bit            pend [NC];
    logic          pw   [NC];
    logic [AW-1:0] pa   [NC];
    logic [DW-1:0] pd   [NC];
    logic [NC-1:0] last_gnt;
    do_reset();
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(AW'(i));
    m_ptr = 2'(NC - 1); m_free = 0; m_acc = -1; m_rv = -1; m_rvc = 2'd0;
    m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rvd = '0;
    last_gnt = '0;
    for (int i = 0; i < NC; i++) begin pend[i] = 1'b0; pw[i] = 1'b0; pa[i] = '0; pd[i] = '0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < NC; i++) begin
        if (last_gnt[i] || (!pend[i] && $urandom_range(0, 3) == 0)) begin
          pend[i] = last_gnt[i] ? 1'($urandom_range(0, 1)) : 1'b1;
          pw[i]   = 1'($urandom_range(0, 1));
          pa[i]   = 10'h040 + 10'($urandom_range(0, 15));
          pd[i]   = $urandom;
        end else if (pend[i] && $urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
        end
        req[i] = pend[i]; we[i] = pw[i]; addr[i] = pa[i]; wdata[i] = pd[i];
      end
      to_sample();
      model_eval(cyc);
      cmp_n++; if (gnt !== exp_gnt) begin err_n++; $display("FAIL rnd_gnt c%0d: got %b want %b", cyc, gnt, exp_gnt); end
      cmp_n++; if (busy !== exp_busy) begin err_n++; $display("FAIL rnd_busy c%0d: got %b want %b", cyc, busy, exp_busy); end
      cmp_n++; if ({mem_en, mem_we} !== {exp_en, exp_mwe}) begin
        err_n++; $display("FAIL rnd_en_we c%0d: got %b want %b", cyc, {mem_en, mem_we}, {exp_en, exp_mwe}); end
      cmp_n++; if (mem_addr !== exp_maddr) begin err_n++; $display("FAIL rnd_addr c%0d: got %h want %h", cyc, mem_addr, exp_maddr); end
      cmp_n++; if (mem_wdata !== exp_mwd) begin err_n++; $display("FAIL rnd_wdata c%0d: got %h want %h", cyc, mem_wdata, exp_mwd); end
      cmp_n++; if (rvalid !== exp_rv) begin err_n++; $display("FAIL rnd_rvalid c%0d: got %b want %b", cyc, rvalid, exp_rv); end
      cmp_n++; if (rdata !== exp_rd) begin err_n++; $display("FAIL rnd_rdata c%0d: got %h want %h", cyc, rdata, exp_rd); end
      last_gnt = exp_gnt;
      to_drive();
    end
    idle_inputs();
    for (int k = 0; k < 8; k++) to_drive();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_latency();
    test_fairness();
    test_withdraw_contention();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parameterised memory access controller that arbitrates N client ports onto one single-port synchronous SRAM. It is the multi-client, configurable-latency successor to the single-requester memory controller. It sits between the datapath clients and the SRAM macro and drives the macro's enable, write-enable, address and write-data pins. It returns read data to the owning client after a configurable read latency.

## Interface
Parameters:
- N_CLIENTS, 4, number of requesting ports (2..8)
- ADDR_W, 10, SRAM address width
- DATA_W, 32, SRAM data width
- RD_LATENCY, 1, cycles from the SRAM-enable edge to valid read data (1..4)

Ports:
- clk_i  in  1  clock, all logic is rising-edge
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  [N_CLIENTS-1:0]  per-client access request
- we_i  in  [N_CLIENTS-1:0]  per-client write (1) / read (0)
- addr_i  in  [N_CLIENTS-1:0][ADDR_W-1:0]  per-client address
- wdata_i  in  [N_CLIENTS-1:0][DATA_W-1:0]  per-client write data
- gnt_o  out  [N_CLIENTS-1:0]  one-hot grant, request accepted this cycle
- rvalid_o  out  [N_CLIENTS-1:0]  one-hot, rdata_o valid for that client
- rdata_o  out  DATA_W  read data, shared by all clients
- busy_o  out  1  high when the controller is not in IDLE
- mem_en_o  out  1  SRAM enable
- mem_we_o  out  1  SRAM write enable
- mem_addr_o  out  ADDR_W  SRAM address
- mem_wdata_o  out  DATA_W  SRAM write data
- mem_rdata_i  in  DATA_W  SRAM read data

## Operation
- FSM states:
  - STATE_IDLE: arbitrate.
  - STATE_ACCESS: drive SRAM for one cycle.
  - STATE_WAIT: count down the read latency.
- IDLE:
  - If any req_i is high, the round-robin winner gets gnt_o high in the same cycle. gnt_o is combinational from req_i and the pointer.
  - The winner's we/addr/wdata and index are registered.
  - Next state is ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - mem_en_o=1; mem_we_o=registered we; mem_addr_o and mem_wdata_o come from the registers.
  - For a write, next state is IDLE.
  - For a read, load the latency counter with RD_LATENCY; next state is WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter equals 1: rvalid_o[owner]=1, rdata_o=mem_rdata_i (pass-through), next state is IDLE.
- Round-robin:
  - The search starts at pointer+1 mod N_CLIENTS.
  - The pointer is set to the winner index on each grant.
  - Reset value is N_CLIENTS-1, so client 0 has first priority.
- gnt_o is asserted only in IDLE and is never asserted to more than one client.
- Client rules:
  - Hold req_i and the request fields stable until gnt_o.
  - Withdrawing req_i before grant is legal.
  - The granted client drops req_i after gnt_o, or keeps it high to queue its next access.
- mem_addr_o, mem_wdata_o and mem_we_o are zero when mem_en_o=0.
- rdata_o is zero whenever no rvalid_o bit is high.

## Timing
- Reset: state IDLE, pointer N_CLIENTS-1, counter 0. All outputs 0 except gnt_o, which follows req_i combinationally in IDLE.
- Write: grant in cycle t, SRAM write in t+1, next grant possible in t+2.
- Read: grant in t, SRAM enable in t+1, rvalid_o in t+1+RD_LATENCY, next grant possible in t+2+RD_LATENCY.
- Throughput: one access per 2 cycles for writes, and per 2+RD_LATENCY cycles for reads. No overlap between accesses.
- Simultaneous requests are resolved purely by the round-robin pointer. Read and write requests have equal priority.
- Reset asserted mid-access:
  - The FSM returns to IDLE immediately.
  - No rvalid_o is produced for the in-flight read.
  - mem_en_o drops asynchronously.
- busy_o = (state != IDLE).

## Structure
- Package mem_pkg holds:
  - the state_t enum (STATE_IDLE, STATE_ACCESS, STATE_WAIT)
  - MAX_RD_LATENCY=4
  - the clog2-derived counter width
- Sub-module rr_arbiter holds the round-robin logic (parameter N; req in, one-hot gnt out, pointer register, update strobe).
- Instantiate rr_arbiter once in mem_arbiter.
- Check the parameter ranges with elaboration-time assertions.

## Test plan
- Single write: N=4, client 2 writes 0xDEADBEEF to addr 0x05.
  - gnt_o=4'b0100 in cycle t.
  - mem_en_o=mem_we_o=1, mem_addr_o=0x05, mem_wdata_o=0xDEADBEEF in t+1.
  - busy_o low again in t+2.
- Read latency sweep: RD_LATENCY=1 and 3, client 0 reads addr 0x05 and the model returns 0xDEADBEEF.
  - rvalid_o=4'b0001 with rdata_o=0xDEADBEEF in t+2 and t+4 respectively.
  - No rvalid_o in any other cycle.
- Fairness: all four req_i held high for 8 writes.
  - Grant order 0,1,2,3,0,1,2,3.
  - Each gnt_o is one-hot and spaced 2 cycles apart.
- Withdrawal and contention: client 1 requests during client 3's read wait, then drops req before IDLE. Client 0 requests at the same time.
  - No grant is issued during WAIT.
  - The next grant goes to client 0 only.
- Reset mid-read: assert rst_ni=0 in the WAIT cycle of a RD_LATENCY=3 read.
  - All outputs go to 0 immediately.
  - After release, no rvalid_o appears.
  - The first request from client 0 is granted.
